tally_sequencer: RTL and testbench

//  Top-level election controller. Sequences the Paillier datapath from vote intake to result readout.

---
 rtl/tally_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_tally_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tally_sequencer.sv
// Election flow controller: gates ciphertext blocks into the accumulator one vote at a time,
// triggers the tally at a vote boundary, buffers the decrypted result and streams it over UART.
module tally_sequencer #(
  parameter int REGISTER_SIZE     = 32,
  parameter int NUM_VOTE_BLOCKS   = 128,
  parameter int NUM_RESULT_BLOCKS = 64,
  parameter int VOTE_COUNT_WIDTH  = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        tally_btn_in,
  input  logic                        spi_valid_in,
  input  logic [REGISTER_SIZE-1:0]    spi_data_in,
  input  logic                        accum_done_in,
  output logic                        mult_valid_out,
  output logic [REGISTER_SIZE-1:0]    mult_data_out,
  output logic                        compute_tally_out,
  input  logic                        result_valid_in,
  input  logic [REGISTER_SIZE-1:0]    result_block_in,
  input  logic                        uart_busy_in,
  output logic                        uart_trigger_out,
  output logic [7:0]                  uart_byte_out,
  output logic [2:0]                  state_out,
  output logic [VOTE_COUNT_WIDTH-1:0] vote_count_out,
  output logic                        overrun_out
);

  localparam int BYTES_PER_BLOCK = REGISTER_SIZE / 8;
  localparam int TOTAL_BYTES     = NUM_RESULT_BLOCKS * BYTES_PER_BLOCK;
  localparam int VB_W            = $clog2(NUM_VOTE_BLOCKS);
  localparam int RI_W            = $clog2(NUM_RESULT_BLOCKS);
  localparam int BI_W            = $clog2(TOTAL_BYTES + 1);
  localparam int LANE_W          = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;

  typedef enum logic [2:0] {
    S_VOTING     = 3'd0,
    S_WAIT_ACCUM = 3'd1,
    S_TALLY      = 3'd2,
    S_DECRYPT    = 3'd3,
    S_SEND       = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  // Per-byte handshake: wait for idle, fire trigger, then skip one cycle of stale busy.
  typedef enum logic [1:0] {
    SP_WAIT = 2'd0,
    SP_TRIG = 2'd1,
    SP_HOLD = 2'd2
  } send_phase_t;

  state_t                      state_q, state_d;
  send_phase_t                 phase_q, phase_d;
  logic [VB_W-1:0]             vote_blk_q;
  logic [VOTE_COUNT_WIDTH-1:0] vote_count_q;
  logic [RI_W-1:0]             res_idx_q;
  logic [BI_W-1:0]             byte_idx_q;
  logic [7:0]                  byte_q;
  logic                        btn_q;
  logic                        pending_q;
  logic                        overrun_q;

  logic [REGISTER_SIZE-1:0]    result_buf [NUM_RESULT_BLOCKS];

  logic                        tally_edge;
  logic                        tally_req;
  logic                        last_vote_blk;
  logic                        last_res;
  logic                        all_sent;
  logic                        block_accept;
  logic                        result_write;
  logic                        byte_load;
  logic                        send_done;

  logic [RI_W-1:0]             rd_blk;
  logic [LANE_W-1:0]           rd_lane;
  logic [REGISTER_SIZE-1:0]    rd_word;
  logic [7:0]                  cur_byte;

  assign tally_edge    = tally_btn_in & ~btn_q;
  assign tally_req     = pending_q | tally_edge;
  assign last_vote_blk = (vote_blk_q == VB_W'(NUM_VOTE_BLOCKS - 1));
  assign last_res      = (res_idx_q == RI_W'(NUM_RESULT_BLOCKS - 1));
  assign all_sent      = (byte_idx_q == BI_W'(TOTAL_BYTES));

  // Byte selection: block index is the upper part of the byte index, lane the lower part.
  always_comb begin
    rd_blk   = RI_W'(byte_idx_q / BI_W'(BYTES_PER_BLOCK));
    rd_lane  = LANE_W'(byte_idx_q % BI_W'(BYTES_PER_BLOCK));
    rd_word  = result_buf[rd_blk];
    cur_byte = rd_word[{rd_lane, 3'b000} +: 8];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_VOTING;
      phase_q <= SP_WAIT;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    state_d           = state_q;
    phase_d           = phase_q;
    mult_valid_out    = 1'b0;
    mult_data_out     = '0;
    compute_tally_out = 1'b0;
    uart_trigger_out  = 1'b0;
    block_accept      = 1'b0;
    result_write      = 1'b0;
    byte_load         = 1'b0;
    send_done         = 1'b0;

    unique case (state_q)
      S_VOTING: begin
        if ((vote_blk_q == '0) && tally_req) begin
          state_d = S_TALLY;
        end else if (spi_valid_in) begin
          block_accept   = 1'b1;
          mult_valid_out = 1'b1;
          mult_data_out  = spi_data_in;
          if (last_vote_blk) state_d = S_WAIT_ACCUM;
        end
      end

      S_WAIT_ACCUM: begin
        if (accum_done_in) state_d = tally_req ? S_TALLY : S_VOTING;
      end

      S_TALLY: begin
        compute_tally_out = 1'b1;
        state_d           = S_DECRYPT;
      end

      S_DECRYPT: begin
        if (result_valid_in) begin
          result_write = 1'b1;
          if (last_res) begin
            state_d = S_SEND;
            phase_d = SP_WAIT;
          end
        end
      end

      S_SEND: begin
        unique case (phase_q)
          SP_WAIT: begin
            if (!uart_busy_in) begin
              if (all_sent) begin
                send_done = 1'b1;
                state_d   = S_DONE;
              end else begin
                byte_load = 1'b1;
                phase_d   = SP_TRIG;
              end
            end
          end
          SP_TRIG: begin
            uart_trigger_out = 1'b1;
            phase_d          = SP_HOLD;
          end
          SP_HOLD: phase_d = SP_WAIT;
          default: phase_d = SP_WAIT;
        endcase
      end

      S_DONE: ;

      default: state_d = S_VOTING;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vote_blk_q   <= '0;
      vote_count_q <= '0;
      res_idx_q    <= '0;
      byte_idx_q   <= '0;
      byte_q       <= '0;
      btn_q        <= 1'b0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      btn_q <= tally_btn_in;

      if (block_accept) vote_blk_q <= last_vote_blk ? '0 : vote_blk_q + 1'b1;
      if (block_accept && last_vote_blk && (vote_count_q != '1))
        vote_count_q <= vote_count_q + 1'b1;

      // Requests after the tally has started are dropped, not queued.
      if (tally_edge && ((state_q == S_VOTING) || (state_q == S_WAIT_ACCUM)))
        pending_q <= 1'b1;
      else if (state_q == S_TALLY)
        pending_q <= 1'b0;

      if ((state_q == S_WAIT_ACCUM) && spi_valid_in) overrun_q <= 1'b1;

      if (result_write) res_idx_q <= last_res ? '0 : res_idx_q + 1'b1;

      if (byte_load) begin
        byte_q     <= cur_byte;
        byte_idx_q <= byte_idx_q + 1'b1;
      end else if (send_done) begin
        byte_q <= '0;
      end
    end
  end

  // NOTE: the result buffer is plain storage with no reset; it is always fully rewritten before it is read.
  always_ff @(posedge clk_in) begin
    if (result_write) result_buf[res_idx_q] <= result_block_in;
  end

  assign uart_byte_out  = byte_q;
  assign state_out      = state_q;
  assign vote_count_out = vote_count_q;
  assign overrun_out    = overrun_q;

endmodule

// File: tb/tb_tally_sequencer.sv
// Directed bench for tally_sequencer: vote intake, deferred tally, overrun, result readout
// over a modelled UART with configurable busy time, and reset abort during readout.
module tb_tally_sequencer;

  localparam int RS     = 32;
  localparam int NVB    = 128;
  localparam int NRB    = 64;
  localparam int VCW    = 16;
  localparam int NBYTES = NRB * RS / 8;

  logic           clk_in;
  logic           rst_in;
  logic           tally_btn_in;
  logic           spi_valid_in;
  logic [RS-1:0]  spi_data_in;
  logic           accum_done_in;
  logic           mult_valid_out;
  logic [RS-1:0]  mult_data_out;
  logic           compute_tally_out;
  logic           result_valid_in;
  logic [RS-1:0]  result_block_in;
  logic           uart_busy_in;
  logic           uart_trigger_out;
  logic [7:0]     uart_byte_out;
  logic [2:0]     state_out;
  logic [VCW-1:0] vote_count_out;
  logic           overrun_out;

  int vectors     = 0;
  int miscompares = 0;

  int         mv_cnt   = 0;
  int         ct_cnt   = 0;
  int         trig_cnt = 0;
  int         busy_len = 0;
  int         busy_cnt = 0;
  logic       arm      = 1'b0;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] sent_bytes [NBYTES];
  logic [RS-1:0] res_blk [NRB];

  tally_sequencer #(
    .REGISTER_SIZE    (RS),
    .NUM_VOTE_BLOCKS  (NVB),
    .NUM_RESULT_BLOCKS(NRB),
    .VOTE_COUNT_WIDTH (VCW)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .tally_btn_in     (tally_btn_in),
    .spi_valid_in     (spi_valid_in),
    .spi_data_in      (spi_data_in),
    .accum_done_in    (accum_done_in),
    .mult_valid_out   (mult_valid_out),
    .mult_data_out    (mult_data_out),
    .compute_tally_out(compute_tally_out),
    .result_valid_in  (result_valid_in),
    .result_block_in  (result_block_in),
    .uart_busy_in     (uart_busy_in),
    .uart_trigger_out (uart_trigger_out),
    .uart_byte_out    (uart_byte_out),
    .state_out        (state_out),
    .vote_count_out   (vote_count_out),
    .overrun_out      (overrun_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic stream(input int n, input logic [RS-1:0] base);
    for (int i = 0; i < n; i++) begin
      spi_valid_in = 1'b1;
      spi_data_in  = base + RS'(i);
      if (i == 0) begin
        #1;
        check("fwd_first_valid", mult_valid_out, 1'b1);
        check("fwd_first_data", mult_data_out, base);
      end
      step();
    end
    spi_valid_in = 1'b0;
    spi_data_in  = '0;
  endtask

  task automatic accum_pulse();
    accum_done_in = 1'b1;
    step();
    accum_done_in = 1'b0;
  endtask

  task automatic feed_results();
    for (int i = 0; i < NRB; i++) begin
      result_valid_in = 1'b1;
      result_block_in = res_blk[i];
      step();
    end
    result_valid_in = 1'b0;
    result_block_in = '0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    for (int c = 0; c < budget && state_out !== s; c++) step();
    check(tag, state_out, s);
  endtask

  task automatic do_reset();
    tally_btn_in = 1'b0;
    rst_in = 1'b0;
    #1;
    check("rst_state", state_out, 3'd0);
    check("rst_vote_count", vote_count_out, '0);
    check("rst_overrun", overrun_out, 1'b0);
    step();
    rst_in = 1'b1;
  endtask

  // Monitor and UART model: busy rises the cycle after the trigger cycle, for busy_len cycles.
  initial begin
    uart_busy_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        busy_cnt     = 0;
        arm          = 1'b0;
        uart_busy_in = 1'b0;
      end else begin
        if (mult_valid_out) mv_cnt++;
        if (compute_tally_out) ct_cnt++;
        if (uart_busy_in) check("byte_stable_busy", uart_byte_out, last_byte);
        if (uart_trigger_out) begin
          check("no_trig_while_busy", uart_busy_in, 1'b0);
          last_byte = uart_byte_out;
          if (trig_cnt < NBYTES) sent_bytes[trig_cnt] = uart_byte_out;
          trig_cnt++;
        end
        if (arm) begin
          arm      = 1'b0;
          busy_cnt = busy_len;
        end
        if (busy_cnt > 0) begin
          uart_busy_in = 1'b1;
          busy_cnt--;
        end else begin
          uart_busy_in = 1'b0;
        end
        if (uart_trigger_out) arm = 1'b1;
      end
    end
  end

  initial begin
    int t0;
    logic [7:0] exp_byte;

    rst_in          = 1'b0;
    tally_btn_in    = 1'b0;
    spi_valid_in    = 1'b0;
    spi_data_in     = '0;
    accum_done_in   = 1'b0;
    result_valid_in = 1'b0;
    result_block_in = '0;

    #3;
    check("reset_state", state_out, 3'd0);
    check("reset_mult_valid", mult_valid_out, 1'b0);
    check("reset_mult_data", mult_data_out, '0);
    check("reset_compute", compute_tally_out, 1'b0);
    check("reset_trigger", uart_trigger_out, 1'b0);
    check("reset_byte", uart_byte_out, 8'h00);
    check("reset_vote_count", vote_count_out, '0);
    check("reset_overrun", overrun_out, 1'b0);
    step();
    step();
    rst_in = 1'b1;

    // Two full votes with accumulator completion after each.
    stream(NVB, 32'h1000_0000);
    check("v1_wait_accum", state_out, 3'd1);
    accum_pulse();
    check("v1_back_voting", state_out, 3'd0);
    stream(NVB, 32'h2000_0000);
    check("v2_wait_accum", state_out, 3'd1);
    accum_pulse();
    check("two_votes_fwd_count", mv_cnt, 256);
    check("two_votes_count", vote_count_out, 16'd2);
    check("two_votes_state", state_out, 3'd0);
    check("two_votes_overrun", overrun_out, 1'b0);

    // A block arriving while the accumulator reduces is dropped and flagged.
    stream(NVB, 32'h3000_0000);
    check("v3_wait_accum", state_out, 3'd1);
    spi_valid_in = 1'b1;
    spi_data_in  = 32'hDEAD_BEEF;
    #1;
    check("overrun_no_fwd_valid", mult_valid_out, 1'b0);
    check("overrun_no_fwd_data", mult_data_out, '0);
    step();
    spi_valid_in = 1'b0;
    spi_data_in  = '0;
    check("overrun_set", overrun_out, 1'b1);
    check("overrun_fwd_count", mv_cnt, 384);
    accum_pulse();
    check("v3_back_voting", state_out, 3'd0);
    check("overrun_sticky", overrun_out, 1'b1);
    check("v3_count", vote_count_out, 16'd3);

    // Tally requested mid-vote waits for the vote boundary and accumulator completion.
    stream(50, 32'h4000_0000);
    tally_btn_in = 1'b1;
    stream(NVB - 50, 32'h4000_0032);
    check("midvote_no_tally", ct_cnt, 0);
    check("midvote_wait_accum", state_out, 3'd1);
    repeat (3) step();
    check("midvote_still_no_tally", ct_cnt, 0);
    accum_pulse();
    check("deferred_tally_state", state_out, 3'd2);
    check("deferred_tally_pulse", compute_tally_out, 1'b1);
    step();
    check("deferred_decrypt", state_out, 3'd3);
    check("deferred_one_pulse", ct_cnt, 1);
    check("deferred_pulse_low", compute_tally_out, 1'b0);
    check("v4_count", vote_count_out, 16'd4);
    tally_btn_in = 1'b0;

    // Readout with a slow UART (busy 10 cycles per byte).
    for (int k = 0; k < NRB; k++) res_blk[k] = 32'h9E37_79B9 * RS'(k + 1);
    busy_len = 10;
    trig_cnt = 0;
    feed_results();
    check("slow_send_state", state_out, 3'd4);
    wait_state(3'd5, 6000, "slow_done");
    check("slow_trig_count", trig_cnt, NBYTES);
    for (int n = 0; n < NBYTES; n++) begin
      exp_byte = 8'(res_blk[n / 4] >> (8 * (n % 4)));
      check("slow_byte", sent_bytes[n], exp_byte);
    end
    check("vote_kept_after_tally", vote_count_out, 16'd4);
    tally_btn_in = 1'b1;
    repeat (5) step();
    check("done_idle_trig", trig_cnt, NBYTES);
    check("done_holds", state_out, 3'd5);
    check("done_no_tally", ct_cnt, 1);

    // Zero-vote tally, result bytes 0x00..0xFF.
    do_reset();
    busy_len = 2;
    trig_cnt = 0;
    ct_cnt   = 0;
    for (int k = 0; k < NRB; k++)
      res_blk[k] = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
    tally_btn_in = 1'b1;
    step();
    check("zero_vote_tally_state", state_out, 3'd2);
    check("zero_vote_tally_pulse", compute_tally_out, 1'b1);
    step();
    tally_btn_in = 1'b0;
    check("zero_vote_decrypt", state_out, 3'd3);
    check("zero_vote_pulse_count", ct_cnt, 1);
    check("zero_vote_count", vote_count_out, '0);
    spi_valid_in = 1'b1;
    spi_data_in  = 32'h1234_5678;
    #1;
    check("decrypt_spi_ignored", mult_valid_out, 1'b0);
    step();
    spi_valid_in = 1'b0;
    spi_data_in  = '0;
    check("decrypt_no_overrun", overrun_out, 1'b0);
    feed_results();
    check("zero_vote_send", state_out, 3'd4);
    wait_state(3'd5, 3000, "zero_vote_done");
    check("zero_vote_trig_count", trig_cnt, NBYTES);
    for (int n = 0; n < NBYTES; n++) begin
      exp_byte = 8'(n);
      check("seq_byte", sent_bytes[n], exp_byte);
    end

    // One vote, tally edge together with accum_done, then reset during readout.
    do_reset();
    ct_cnt = 0;
    stream(NVB, 32'h5000_0000);
    check("v5_wait_accum", state_out, 3'd1);
    tally_btn_in  = 1'b1;
    accum_done_in = 1'b1;
    step();
    accum_done_in = 1'b0;
    check("edge_with_accum_tally", state_out, 3'd2);
    step();
    tally_btn_in = 1'b0;
    check("v5_decrypt", state_out, 3'd3);
    check("v5_count", vote_count_out, 16'd1);
    busy_len = 10;
    trig_cnt = 0;
    feed_results();
    for (int c = 0; c < 1000 && trig_cnt < 20; c++) step();
    check("abort_send_progress", (trig_cnt >= 20), 1'b1);
    #1;
    rst_in = 1'b0;
    #1;
    check("abort_state", state_out, 3'd0);
    check("abort_trigger", uart_trigger_out, 1'b0);
    check("abort_byte", uart_byte_out, 8'h00);
    check("abort_vote_count", vote_count_out, '0);
    check("abort_overrun", overrun_out, 1'b0);
    check("abort_mult_valid", mult_valid_out, 1'b0);
    check("abort_compute", compute_tally_out, 1'b0);
    step();
    rst_in = 1'b1;
    step();
    check("abort_release_state", state_out, 3'd0);
    t0 = trig_cnt;
    repeat (20) step();
    check("abort_no_more_trig", trig_cnt, t0);
    check("abort_stays_voting", state_out, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
